// File: rtl/replacement_controller.sv
// Cache miss-handling controller: picks a victim way from valid bits and the LRU
// one-hot, sequences writeback/refill handshakes, then strobes the LRU update.
module replacement_controller #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              miss_req,
  input  logic [INDEX_BITS-1:0]             miss_index,
  output logic                              miss_ready,
  output logic [INDEX_BITS-1:0]             lru_index,
  input  logic [WIDTH-1:0]                  lru,
  input  logic [WIDTH-1:0]                  way_valid,
  input  logic [WIDTH-1:0]                  way_dirty,
  output logic [$clog2(WIDTH)-1:0]          lru_access,
  output logic                              lru_access_valid,
  output logic                              wb_req,
  input  logic                              wb_ack,
  output logic                              fill_req,
  input  logic                              fill_ack,
  output logic [$clog2(WIDTH)-1:0]          victim_way,
  output logic                              done,
  output logic                              lru_error
);

  localparam int unsigned WAY_BITS = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SELECT,
    S_WB,
    S_FILL,
    S_UPDATE
  } state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   idx_q, idx_d;
  logic [WAY_BITS-1:0]     victim_d, access_d;
  logic                    ready_d, wb_req_d, fill_req_d, upd_d, err_d;

  logic                    inv_found, lru_found;
  logic [WAY_BITS-1:0]     inv_way, lru_way, sel_way;
  logic                    sel_err, sel_wb;

  // Lowest-numbered invalid way and lowest-numbered set LRU bit
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    lru_found = 1'b0;
    lru_way   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!way_valid[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(i);
      end
      if (lru[i]) begin
        lru_found = 1'b1;
        lru_way   = WAY_BITS'(i);
      end
    end
  end

  // An all-zero LRU vector with no invalid way falls back to way 0 and flags an error
  assign sel_way = inv_found ? inv_way : (lru_found ? lru_way : '0);
  assign sel_err = !inv_found && !lru_found;
  assign sel_wb  = way_valid[sel_way] && way_dirty[sel_way];

  // LRU read address follows the request while idle so the RAM read starts at accept
  assign lru_index = (state_q == S_IDLE) ? miss_index : idx_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    victim_d   = victim_way;
    err_d      = lru_error;
    wb_req_d   = 1'b0;
    fill_req_d = 1'b0;
    upd_d      = 1'b0;
    access_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          idx_d   = miss_index;
          state_d = S_WAIT;
        end
      end
      S_WAIT:   state_d = S_SELECT;
      S_SELECT: begin
        victim_d = sel_way;
        err_d    = lru_error | sel_err;
        if (sel_wb) begin
          state_d  = S_WB;
          wb_req_d = 1'b1;
        end else begin
          state_d    = S_FILL;
          fill_req_d = 1'b1;
        end
      end
      S_WB: begin
        if (wb_ack) begin
          state_d    = S_FILL;
          fill_req_d = 1'b1;
        end else begin
          wb_req_d = 1'b1;
        end
      end
      S_FILL: begin
        if (fill_ack) begin
          state_d  = S_UPDATE;
          upd_d    = 1'b1;
          access_d = victim_way;
        end else begin
          fill_req_d = 1'b1;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      victim_way       <= '0;
      lru_error        <= 1'b0;
      miss_ready       <= 1'b1;
      wb_req           <= 1'b0;
      fill_req         <= 1'b0;
      lru_access_valid <= 1'b0;
      lru_access       <= '0;
      done             <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      victim_way       <= victim_d;
      lru_error        <= err_d;
      miss_ready       <= ready_d;
      wb_req           <= wb_req_d;
      fill_req         <= fill_req_d;
      lru_access_valid <= upd_d;
      lru_access       <= access_d;
      done             <= upd_d;
    end
  end

endmodule

// File: tb/tb_replacement_controller.sv
// Directed bench for replacement_controller, with a small true-LRU model for the
// back-to-back scenario.
module tb_replacement_controller;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned INDEX_BITS = 8;
  localparam int unsigned WAY_BITS   = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  miss_req;
  logic [INDEX_BITS-1:0] miss_index;
  logic                  miss_ready;
  logic [INDEX_BITS-1:0] lru_index;
  logic [WIDTH-1:0]      lru, lru_drv, model_lru;
  logic [WIDTH-1:0]      way_valid, way_dirty;
  logic [WAY_BITS-1:0]   lru_access, victim_way;
  logic                  lru_access_valid, wb_req, wb_ack, fill_req, fill_ack;
  logic                  done, lru_error;
  logic                  use_model;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  assign lru = use_model ? model_lru : lru_drv;

  replacement_controller #(.WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS)) dut (
    .clock(clock), .reset(reset),
    .miss_req(miss_req), .miss_index(miss_index), .miss_ready(miss_ready),
    .lru_index(lru_index), .lru(lru), .way_valid(way_valid), .way_dirty(way_dirty),
    .lru_access(lru_access), .lru_access_valid(lru_access_valid),
    .wb_req(wb_req), .wb_ack(wb_ack), .fill_req(fill_req), .fill_ack(fill_ack),
    .victim_way(victim_way), .done(done), .lru_error(lru_error)
  );

  // True-LRU model: age 0 = most recent, age 3 = least recent; synchronous read
  logic [1:0] age [256][WIDTH];
  initial begin
    for (int s = 0; s < 256; s++)
      for (int w = 0; w < WIDTH; w++)
        age[s][w] = 2'(w);
  end
  always @(posedge clock) begin
    for (int w = 0; w < WIDTH; w++)
      model_lru[w] <= (age[lru_index][w] == 2'd3);
    if (use_model && lru_access_valid) begin
      for (int w = 0; w < WIDTH; w++)
        if (age[lru_index][w] < age[lru_index][lru_access])
          age[lru_index][w] <= age[lru_index][w] + 2'd1;
      age[lru_index][lru_access] <= 2'd0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; miss_req = 1'b0; miss_index = '0; lru_drv = '0;
    way_valid = '0; way_dirty = '0; wb_ack = 1'b0; fill_ack = 1'b0; use_model = 1'b0;
    tick();
    check("rst_ready", 32'(miss_ready), 32'd1);
    check("rst_wb", 32'(wb_req), 32'd0);
    check("rst_fill", 32'(fill_req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_upd", 32'(lru_access_valid), 32'd0);
    check("rst_victim", 32'(victim_way), 32'd0);
    check("rst_err", 32'(lru_error), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // 1: clean miss
    way_valid = 4'b1111; way_dirty = 4'b0000; lru_drv = 4'b0100;
    miss_index = 8'h3A; miss_req = 1'b1;
    #1 check("t1_idx_idle", 32'(lru_index), 32'h3A);
    tick();                                   // accepted -> WAIT
    miss_req = 1'b0; miss_index = 8'h55;
    check("t1_ready_busy", 32'(miss_ready), 32'd0);
    #1 check("t1_idx_latched", 32'(lru_index), 32'h3A);
    tick();                                   // SELECT
    check("t1_fill_early", 32'(fill_req), 32'd0);
    tick();                                   // FILL
    check("t1_fill", 32'(fill_req), 32'd1);
    check("t1_wb", 32'(wb_req), 32'd0);
    check("t1_victim", 32'(victim_way), 32'd2);
    fill_ack = 1'b1;
    tick();                                   // UPDATE
    fill_ack = 1'b0;
    check("t1_done", 32'(done), 32'd1);
    check("t1_upd", 32'(lru_access_valid), 32'd1);
    check("t1_access", 32'(lru_access), 32'd2);
    check("t1_fill_drop", 32'(fill_req), 32'd0);
    #1 check("t1_idx_update", 32'(lru_index), 32'h3A);
    tick();                                   // IDLE
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_upd_pulse", 32'(lru_access_valid), 32'd0);
    check("t1_ready_back", 32'(miss_ready), 32'd1);

    // 2: dirty victim, writeback ack delayed
    lru_drv = 4'b0001; way_dirty = 4'b0001; miss_index = 8'h11; miss_req = 1'b1;
    tick(); miss_req = 1'b0;
    tick(); tick();                           // WB
    check("t2_wb", 32'(wb_req), 32'd1);
    check("t2_victim", 32'(victim_way), 32'd0);
    check("t2_fill_wait", 32'(fill_req), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("t2_wb_held", 32'(wb_req), 32'd1);
    wb_ack = 1'b1;
    tick();                                   // FILL
    wb_ack = 1'b0;
    check("t2_wb_drop", 32'(wb_req), 32'd0);
    check("t2_fill", 32'(fill_req), 32'd1);
    tick();
    check("t2_no_done", 32'(done), 32'd0);
    fill_ack = 1'b1;
    tick();                                   // UPDATE
    fill_ack = 1'b0;
    check("t2_done", 32'(done), 32'd1);
    check("t2_access", 32'(lru_access), 32'd0);
    tick();

    // 3: invalid way preferred over dirty LRU way
    way_valid = 4'b1011; lru_drv = 4'b0001; way_dirty = 4'b1111;
    miss_index = 8'h22; miss_req = 1'b1;
    tick(); miss_req = 1'b0;
    tick(); tick();
    check("t3_victim", 32'(victim_way), 32'd2);
    check("t3_no_wb", 32'(wb_req), 32'd0);
    check("t3_fill", 32'(fill_req), 32'd1);
    fill_ack = 1'b1; tick(); fill_ack = 1'b0;
    check("t3_access", 32'(lru_access), 32'd2);
    tick();

    // 4: zero LRU vector, then a multi-bit vector
    way_valid = 4'b1111; way_dirty = 4'b0000; lru_drv = 4'b0000;
    miss_index = 8'h33; miss_req = 1'b1;
    tick(); miss_req = 1'b0;
    tick();
    check("t4_err_pre", 32'(lru_error), 32'd0);
    tick();
    check("t4_victim", 32'(victim_way), 32'd0);
    check("t4_err", 32'(lru_error), 32'd1);
    fill_ack = 1'b1; tick(); fill_ack = 1'b0; tick();
    lru_drv = 4'b1010; miss_req = 1'b1;
    tick(); miss_req = 1'b0;
    tick(); tick();
    check("t4_victim2", 32'(victim_way), 32'd1);
    check("t4_err_sticky", 32'(lru_error), 32'd1);
    fill_ack = 1'b1; tick(); fill_ack = 1'b0; tick();

    // 5: held request while busy, stray fill_ack, reset during FILL
    lru_drv = 4'b0001; way_dirty = 4'b0001; miss_index = 8'h44; miss_req = 1'b1;
    tick();
    miss_index = 8'h77;
    tick(); tick();                           // WB, second request still held
    check("t5_ready_busy", 32'(miss_ready), 32'd0);
    #1 check("t5_idx_busy", 32'(lru_index), 32'h44);
    fill_ack = 1'b1;
    tick();
    fill_ack = 1'b0;
    check("t5_stray_wb", 32'(wb_req), 32'd1);
    check("t5_stray_fill", 32'(fill_req), 32'd0);
    wb_ack = 1'b1; tick(); wb_ack = 1'b0;     // FILL
    fill_ack = 1'b1; tick(); fill_ack = 1'b0; // UPDATE
    check("t5_done", 32'(done), 32'd1);
    check("t5_ready_upd", 32'(miss_ready), 32'd0);
    tick();                                   // IDLE, request still held
    check("t5_ready_idle", 32'(miss_ready), 32'd1);
    tick();                                   // accepted -> WAIT
    miss_req = 1'b0;
    check("t5_accept", 32'(miss_ready), 32'd0);
    #1 check("t5_idx2", 32'(lru_index), 32'h77);
    tick(); tick();                           // WB
    wb_ack = 1'b1; tick(); wb_ack = 1'b0;     // FILL
    check("t5_fill", 32'(fill_req), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_fill", 32'(fill_req), 32'd0);
    check("t5_rst_ready", 32'(miss_ready), 32'd1);
    check("t5_rst_err", 32'(lru_error), 32'd0);
    tick();
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_upd", 32'(lru_access_valid), 32'd0);
    reset = 1'b1;
    tick();

    // 6: back-to-back misses to one set against the LRU model
    use_model = 1'b1;
    way_valid = 4'b1111; way_dirty = 4'b0000; miss_index = 8'h3A; miss_req = 1'b1;
    tick(); tick(); tick();                   // FILL
    check("t6_victim1", 32'(victim_way), 32'd3);
    fill_ack = 1'b1; tick(); fill_ack = 1'b0; // UPDATE
    check("t6_access1", 32'(lru_access), 32'd3);
    tick();                                   // IDLE, held request
    tick();                                   // accepted -> WAIT
    miss_req = 1'b0;
    tick(); tick();                           // FILL
    check("t6_victim2", 32'(victim_way), 32'd2);
    fill_ack = 1'b1; tick(); fill_ack = 1'b0;
    check("t6_done2", 32'(done), 32'd1);
    check("t6_access2", 32'(lru_access), 32'd2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
